// File: rtl/alu_pkg.sv
// Shared types and constants for the atomic ALU execution unit.
package alu_pkg;

   localparam int WIDTH = 32;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SLL = 3'b101,
      OP_MUL = 3'b110,
      OP_CMP = 3'b111
   } alu_op_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_MUL   = 2'd2
   } alu_state_t;

endpackage

// File: rtl/atomic_alu_core_if.sv
// Controller-to-ALU request/response bundle; the controller is the master.
interface atomic_alu_core_if;

   logic [2:0]                alu_op_code;
   logic [alu_pkg::WIDTH-1:0] data_a;
   logic [alu_pkg::WIDTH-1:0] data_b;
   logic                      op_valid;
   logic                      op_ready;
   logic [alu_pkg::WIDTH-1:0] y;
   logic                      Z;
   logic                      C;
   logic                      done;

   modport master (
      output alu_op_code, data_a, data_b, op_valid,
      input  op_ready, y, Z, C, done
   );

   modport slave (
      input  alu_op_code, data_a, data_b, op_valid,
      output op_ready, y, Z, C, done
   );

endinterface

// File: rtl/alu_mul_seq.sv
// 32-iteration shift-add multiplier; done_o and product_o are combinational so the
// caller can register the product on the same edge as the final iteration.
module alu_mul_seq
   import alu_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [2*WIDTH-1:0]   product_o
);

   logic                 busy_q, busy_d;
   logic [4:0]           cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   acc_next;

   assign acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign busy_o    = busy_q;
   assign done_o    = busy_q && (cnt_q == 5'd31);
   assign product_o = acc_next;

   always_comb begin
      busy_d   = busy_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      if (start_i && !busy_q) begin
         busy_d   = 1'b1;
         cnt_d    = 5'd0;
         mcand_d  = {{WIDTH{1'b0}}, a_i};
         mplier_d = b_i;
         acc_d    = '0;
      end else if (busy_q) begin
         // One multiplier bit per edge: multiplicand walks left, multiplier walks right.
         acc_d    = acc_next;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 5'd1;
         if (cnt_q == 5'd31) busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q   <= 1'b0;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else begin
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
      end
   end

endmodule

// File: rtl/atomic_alu_core.sv
// ALU execution unit: single-cycle logic/add/sub/cmp, iterative SLL and MUL,
// registered y/Z/C with a one-cycle done pulse.
module atomic_alu_core
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   atomic_alu_core_if.slave  bus
);

   alu_state_t           state_q, state_d;
   logic [WIDTH-1:0]     y_q, y_d;
   logic                 z_q, z_d;
   logic                 c_q, c_d;
   logic                 done_q, done_d;
   logic [WIDTH-1:0]     sh_acc_q, sh_acc_d;
   logic [4:0]           sh_cnt_q, sh_cnt_d;

   alu_op_t              op;
   logic                 accept;
   logic                 mul_start, mul_busy, mul_done;
   logic [2*WIDTH-1:0]   mul_prod;
   logic [WIDTH:0]       sum_w;
   logic [WIDTH-1:0]     sc_res;
   logic                 sc_c;
   logic [WIDTH-1:0]     sh_last;

   assign op           = alu_op_t'(bus.alu_op_code);
   assign bus.op_ready = (state_q == S_IDLE) && !mul_busy;
   assign accept       = bus.op_valid && bus.op_ready;
   assign mul_start    = accept && (op == OP_MUL);
   assign sh_last      = sh_acc_q << 1;

   assign bus.y    = y_q;
   assign bus.Z    = z_q;
   assign bus.C    = c_q;
   assign bus.done = done_q;

   alu_mul_seq u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (mul_start),
      .a_i       (bus.data_a),
      .b_i       (bus.data_b),
      .busy_o    (mul_busy),
      .done_o    (mul_done),
      .product_o (mul_prod)
   );

   // SUB and CMP share one path; C is the "no borrow" flag the CAS compare relies on.
   always_comb begin
      sum_w  = {1'b0, bus.data_a} + {1'b0, bus.data_b};
      sc_res = '0;
      sc_c   = 1'b0;
      case (op)
         OP_ADD:         begin sc_res = sum_w[WIDTH-1:0]; sc_c = sum_w[WIDTH]; end
         OP_SUB, OP_CMP: begin sc_res = bus.data_a - bus.data_b; sc_c = (bus.data_a >= bus.data_b); end
         OP_AND:         sc_res = bus.data_a & bus.data_b;
         OP_OR:          sc_res = bus.data_a | bus.data_b;
         OP_XOR:         sc_res = bus.data_a ^ bus.data_b;
         OP_SLL:         sc_res = bus.data_a << bus.data_b[4:0];
         default:        sc_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      y_d      = y_q;
      z_d      = z_q;
      c_d      = c_q;
      done_d   = 1'b0;
      sh_acc_d = sh_acc_q;
      sh_cnt_d = sh_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (op == OP_MUL) begin
                  state_d = S_MUL;
               end else if ((op == OP_SLL) && (bus.data_b[4:0] != 5'd0)) begin
                  state_d  = S_SHIFT;
                  sh_acc_d = bus.data_a;
                  sh_cnt_d = bus.data_b[4:0];
               end else begin
                  y_d    = sc_res;
                  z_d    = (sc_res == '0);
                  c_d    = sc_c;
                  done_d = 1'b1;
               end
            end
         end
         S_SHIFT: begin
            sh_acc_d = sh_last;
            sh_cnt_d = sh_cnt_q - 5'd1;
            if (sh_cnt_q == 5'd1) begin
               y_d     = sh_last;
               z_d     = (sh_last == '0);
               c_d     = 1'b0;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_MUL: begin
            if (mul_done) begin
               y_d     = mul_prod[WIDTH-1:0];
               z_d     = (mul_prod[WIDTH-1:0] == '0);
               c_d     = |mul_prod[2*WIDTH-1:WIDTH];
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         y_q      <= '0;
         z_q      <= 1'b0;
         c_q      <= 1'b0;
         done_q   <= 1'b0;
         sh_acc_q <= '0;
         sh_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         y_q      <= y_d;
         z_q      <= z_d;
         c_q      <= c_d;
         done_q   <= done_d;
         sh_acc_q <= sh_acc_d;
         sh_cnt_q <= sh_cnt_d;
      end
   end

endmodule

// File: tb/tb_atomic_alu_core.sv
// Scoreboard bench for atomic_alu_core: directed vectors push expectations, a
// negedge monitor pops one per done pulse.
module tb_atomic_alu_core;
   import alu_pkg::*;

   typedef struct {
      logic [31:0] y;
      logic        z;
      logic        c;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   exp_t exp_q[$];

   atomic_alu_core_if bus ();

   atomic_alu_core dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=1 required=0 (y=0x%08h)", bus.y);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_y", bus.y, e.y);
            chk("sb_Z", {31'b0, bus.Z}, {31'b0, e.z});
            chk("sb_C", {31'b0, bus.C}, {31'b0, e.c});
         end
      end
   end

   // Waits (bounded) for op_ready; returns the number of edges waited.
   task automatic wait_ready(output int n);
      n = 0;
      while (!bus.op_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) chk("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ey, input logic ez, input logic ec, input bit expect_done);
      int n;
      wait_ready(n);
      bus.alu_op_code = op;
      bus.data_a      = a;
      bus.data_b      = b;
      bus.op_valid    = 1'b1;
      if (expect_done) exp_q.push_back('{y: ey, z: ez, c: ec});
      @(posedge clk); #1;
      bus.op_valid    = 1'b0;
   endtask

   initial begin
      int n;
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      bus.op_valid    = 1'b0;
      bus.alu_op_code = 3'b0;
      bus.data_a      = '0;
      bus.data_b      = '0;

      // Reset with random inputs.
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         bus.op_valid    = 1'($urandom);
         bus.alu_op_code = 3'($urandom);
         bus.data_a      = $urandom;
         bus.data_b      = $urandom;
      end
      chk("rst_y", bus.y, 32'h0);
      chk("rst_Z", {31'b0, bus.Z}, 32'h0);
      chk("rst_C", {31'b0, bus.C}, 32'h0);
      chk("rst_done", {31'b0, bus.done}, 32'h0);
      chk("rst_ready", {31'b0, bus.op_ready}, 32'h1);
      bus.op_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Back-to-back single-cycle ops.
      send(OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b1, 1'b1);
      chk("b2b_done0", {31'b0, bus.done}, 32'h1);
      send(OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
      chk("b2b_done1", {31'b0, bus.done}, 32'h1);
      send(OP_CMP, 32'h1234, 32'h1234, 32'h0, 1'b1, 1'b1, 1'b1);
      chk("b2b_done2", {31'b0, bus.done}, 32'h1);
      @(posedge clk); #1;
      chk("b2b_done_end", {31'b0, bus.done}, 32'h0);

      // Logic ops and further arithmetic boundaries.
      send(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b1);
      send(OP_OR,  32'h0000_00F0, 32'h0F00_000F, 32'h0F00_00FF, 1'b0, 1'b0, 1'b1);
      send(OP_XOR, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0, 1'b1, 1'b0, 1'b1);
      send(OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
      send(OP_SUB, 32'd9, 32'd4, 32'd5, 1'b0, 1'b1, 1'b1);
      send(OP_CMP, 32'd3, 32'd4, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);

      // SLL by 31: op_ready low for 31 cycles, done with the result.
      send(OP_SLL, 32'h1, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
      wait_ready(n);
      chk("sll31_busy_cycles", n, 32'd31);
      chk("sll31_done", {31'b0, bus.done}, 32'h1);
      // SLL by 32 wraps to shift 0: single-cycle.
      send(OP_SLL, 32'hDEAD_BEEF, 32'd32, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
      chk("sll32_done", {31'b0, bus.done}, 32'h1);
      send(OP_SLL, 32'h8000_0001, 32'd1, 32'h0000_0002, 1'b0, 1'b0, 1'b1);
      wait_ready(n);
      chk("sll1_busy_cycles", n, 32'd1);

      // MUL with overflow, then a MUL accepted in the done cycle.
      send(OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, 1'b1, 1'b1);
      wait_ready(n);
      chk("mul_busy_cycles", n, 32'd32);
      chk("mul_done", {31'b0, bus.done}, 32'h1);
      send(OP_MUL, 32'd1234, 32'd5678, 32'd7006652, 1'b0, 1'b0, 1'b1);

      // Held request during MUL with different operands is taken only when ready.
      send(OP_MUL, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0, 1'b1);
      bus.alu_op_code = OP_ADD;
      bus.data_a      = 32'd100;
      bus.data_b      = 32'd200;
      bus.op_valid    = 1'b1;
      exp_q.push_back('{y: 32'd300, z: 1'b0, c: 1'b0});
      n = 0;
      while (!bus.op_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("hold_wait_cycles", n, 32'd32);
      @(posedge clk); #1;
      bus.op_valid = 1'b0;
      chk("hold_add_done", {31'b0, bus.done}, 32'h1);
      chk("hold_add_y", bus.y, 32'd300);

      // Reset during a MUL: no done, outputs return to reset values.
      send(OP_MUL, 32'hFFFF, 32'hFFFF, 32'h0, 1'b0, 1'b0, 1'b0);
      repeat (9) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      chk("abort_y", bus.y, 32'h0);
      chk("abort_done", {31'b0, bus.done}, 32'h0);
      chk("abort_ready", {31'b0, bus.op_ready}, 32'h1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (40) begin @(posedge clk); #1; end
      send(OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b1);
      chk("post_rst_add_y", bus.y, 32'd5);

      repeat (3) begin @(posedge clk); #1; end
      chk("sb_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
